regfile_xfer_ctrl: RTL and testbench

REGFILE_XFER_CTRL -- requirements
Module: regfile_xfer_ctrl

---
 rtl/xfer_pkg.sv | 25 ++
 rtl/onehot_dec.sv | 15 +
 rtl/regfile_xfer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_regfile_xfer_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared types and constants for the register-file transfer controller.
// XFER_SETTLE_EN adds the SETTLE state to state_t.
package xfer_pkg;

    localparam int NREGS = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_ALU  = 2'b01,
        OP_IMM  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
`ifdef XFER_SETTLE_EN
        S_SETTLE,
`endif
        S_LATCH,
        S_RELEASE
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec
    import xfer_pkg::*;
(
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [NREGS-1:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) y_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/regfile_xfer_ctrl.sv
// Register-file transfer sequencer: DRIVE -> [SETTLE] -> LATCH -> RELEASE.
// Define XFER_SETTLE_EN to insert SETTLE_CYCLES bus-settle cycles.
module regfile_xfer_ctrl
    import xfer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [1:0]       OP,
    input  logic [SEL_W-1:0] SRC_SEL,
    input  logic [SEL_W-1:0] DST_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [NREGS-1:0] LOAD,
    output logic [NREGS-1:0] ASSERT_MAIN_bar,
    output logic [NREGS-1:0] ASSERT_LHS_bar,
    output logic [NREGS-1:0] ASSERT_RHS_bar,
    output logic             ALU_ASSERT_bar,
    output logic             IMM_ASSERT_bar
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [NREGS-1:0] load_q, load_d;
    logic [NREGS-1:0] main_bar_q, lhs_bar_q, rhs_bar_q;
    logic             alu_bar_q, imm_bar_q;
    logic             alu_bar_d, imm_bar_d;

    logic             drv_en, main_en, lhs_en, rhs_en, load_en;
    logic [NREGS-1:0] main_dec, lhs_dec, rhs_dec;

`ifdef XFER_SETTLE_EN
    logic [3:0] cnt_q, cnt_d;
`else
    logic unused_settle;
    assign unused_settle = |4'(SETTLE_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = 1'b0;
`ifdef XFER_SETTLE_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    if (op_t'(OP) == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = op_t'(OP);
                        src_d   = SRC_SEL;
                        dst_d   = DST_SEL;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
`ifdef XFER_SETTLE_EN
                state_d = S_SETTLE;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
`else
                state_d = S_LATCH;
`endif
            end
`ifdef XFER_SETTLE_EN
            S_SETTLE: begin
                if (cnt_q == 4'd0) state_d = S_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
`endif
            S_LATCH:   state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so every port comes from a flop.
    always_comb begin
        drv_en = (state_d == S_DRIVE) || (state_d == S_LATCH);
`ifdef XFER_SETTLE_EN
        drv_en = drv_en || (state_d == S_SETTLE);
`endif
        main_en   = drv_en && (op_d == OP_MOV);
        lhs_en    = drv_en && (op_d == OP_ALU);
        rhs_en    = lhs_en;
        alu_bar_d = !lhs_en;
        imm_bar_d = !(drv_en && (op_d == OP_IMM));
        load_en   = (state_d == S_LATCH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_RELEASE);
    end

    onehot_dec u_main (.en_i(main_en), .sel_i(src_d), .y_o(main_dec));
    onehot_dec u_lhs  (.en_i(lhs_en),  .sel_i(src_d), .y_o(lhs_dec));
    onehot_dec u_rhs  (.en_i(rhs_en),  .sel_i(dst_d), .y_o(rhs_dec));
    onehot_dec u_load (.en_i(load_en), .sel_i(dst_d), .y_o(load_d));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MOV;
            src_q      <= '0;
            dst_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= '0;
            main_bar_q <= '1;
            lhs_bar_q  <= '1;
            rhs_bar_q  <= '1;
            alu_bar_q  <= 1'b1;
            imm_bar_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            load_q     <= load_d;
            main_bar_q <= ~main_dec;
            lhs_bar_q  <= ~lhs_dec;
            rhs_bar_q  <= ~rhs_dec;
            alu_bar_q  <= alu_bar_d;
            imm_bar_q  <= imm_bar_d;
        end
    end

`ifdef XFER_SETTLE_EN
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ERR             = err_q;
    assign LOAD            = load_q;
    assign ASSERT_MAIN_bar = main_bar_q;
    assign ASSERT_LHS_bar  = lhs_bar_q;
    assign ASSERT_RHS_bar  = rhs_bar_q;
    assign ALU_ASSERT_bar  = alu_bar_q;
    assign IMM_ASSERT_bar  = imm_bar_q;

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Scoreboard bench for regfile_xfer_ctrl: transaction model plus per-cycle monitor.
// Honours XFER_SETTLE_EN (DUT built with SETTLE_CYCLES=3).
module tb_regfile_xfer_ctrl;

    localparam int SETTLE = 3;
`ifdef XFER_SETTLE_EN
    localparam int LAT = 3 + SETTLE;
`else
    localparam int LAT = 3;
`endif

    logic       CLK = 1'b0;
    logic       RST, REQ;
    logic [1:0] OP, SRC_SEL, DST_SEL;
    logic       BUSY, DONE, ERR;
    logic [3:0] LOAD, ASSERT_MAIN_bar, ASSERT_LHS_bar, ASSERT_RHS_bar;
    logic       ALU_ASSERT_bar, IMM_ASSERT_bar;

    regfile_xfer_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP),
        .SRC_SEL(SRC_SEL), .DST_SEL(DST_SEL),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .LOAD(LOAD),
        .ASSERT_MAIN_bar(ASSERT_MAIN_bar),
        .ASSERT_LHS_bar(ASSERT_LHS_bar),
        .ASSERT_RHS_bar(ASSERT_RHS_bar),
        .ALU_ASSERT_bar(ALU_ASSERT_bar),
        .IMM_ASSERT_bar(IMM_ASSERT_bar)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       is_err;
        int       acc;
        bit [1:0] op;
        bit [1:0] src;
        bit [1:0] dst;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    free_at = 0;
    int    checks = 0;
    int    errors = 0;

    // Reference model: a transfer accepted at edge N owns cycles N+1..N+LAT.
    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            free_at = cyc + 1;
        end else if (REQ && cyc >= free_at) begin
            if (OP == 2'b11) begin
                q.push_back('{1'b1, cyc, OP, SRC_SEL, DST_SEL});
            end else begin
                q.push_back('{1'b0, cyc, OP, SRC_SEL, DST_SEL});
                free_at = cyc + LAT + 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge CLK) begin
        logic       e_busy, e_done, e_err, e_alu, e_imm;
        logic [3:0] e_load, e_main, e_lhs, e_rhs;
        logic [20:0] got, exp;
        bit         pop;
        int         d;
        int         lows;
        if (cyc > 0) begin
            e_busy = 0; e_done = 0; e_err = 0;
            e_load = 4'h0; e_main = 4'hF; e_lhs = 4'hF; e_rhs = 4'hF;
            e_alu = 1; e_imm = 1;
            pop = 0;
            if (q.size() > 0) begin
                d = cyc - q[0].acc;
                if (q[0].is_err) begin
                    if (d == 1) begin e_err = 1; pop = 1; end
                end else if (d >= 1 && d <= LAT - 1) begin
                    e_busy = 1;
                    case (q[0].op)
                        2'b00: e_main[q[0].src] = 1'b0;
                        2'b01: begin
                            e_lhs[q[0].src] = 1'b0;
                            e_rhs[q[0].dst] = 1'b0;
                            e_alu = 1'b0;
                        end
                        default: e_imm = 1'b0;
                    endcase
                    if (d == LAT - 1) e_load[q[0].dst] = 1'b1;
                end else if (d == LAT) begin
                    e_busy = 1; e_done = 1; pop = 1;
                end
            end
            got = {BUSY, DONE, ERR, LOAD, ASSERT_MAIN_bar, ASSERT_LHS_bar,
                   ASSERT_RHS_bar, ALU_ASSERT_bar, IMM_ASSERT_bar};
            exp = {e_busy, e_done, e_err, e_load, e_main, e_lhs,
                   e_rhs, e_alu, e_imm};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
            lows = $countones(~ASSERT_MAIN_bar) + int'(!ALU_ASSERT_bar)
                 + int'(!IMM_ASSERT_bar);
            checks++;
            if (lows > 1) begin
                errors++;
                $display("FAIL main_bus_drivers cyc=%0d got=%0d exp<=1", cyc, lows);
            end
            if (pop) void'(q.pop_front());
        end
    end

    task automatic issue(input bit rst, input bit req, input bit [1:0] op,
                         input bit [1:0] src, input bit [1:0] dst);
        RST = rst; REQ = req; OP = op; SRC_SEL = src; DST_SEL = dst;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        RST = 1; REQ = 0; OP = 0; SRC_SEL = 0; DST_SEL = 0;
        for (int i = 0; i < 3; i++) issue(1, 1, 2'b00, 2'b01, 2'b10);
        idle(2);
        issue(0, 1, 2'b00, 2'd1, 2'd3);
        idle(LAT + 2);
        issue(0, 1, 2'b01, 2'd0, 2'd2);
        idle(LAT + 2);
        issue(0, 1, 2'b11, 2'd1, 2'd1);
        idle(3);
        for (int i = 0; i < 2 * (LAT + 1); i++) issue(0, 1, 2'b00, 2'd0, 2'd1);
        idle(LAT + 2);
        issue(0, 1, 2'b10, 2'd3, 2'd0);
        issue(0, 0, 2'b00, 2'd0, 2'd0);
        issue(1, 1, 2'b10, 2'd3, 2'd0);
        idle(LAT + 2);
        issue(0, 1, 2'b00, 2'd2, 2'd0);
        idle(LAT + 2);
        issue(0, 1, 2'b00, 2'd2, 2'd2);
        idle(LAT + 2);
        issue(0, 1, 2'b01, 2'd3, 2'd3);
        idle(LAT + 2);
        for (int i = 0; i < 3000; i++) begin
            issue($urandom_range(99) < 3, $urandom_range(99) < 60,
                  2'($urandom_range(3)), 2'($urandom_range(3)),
                  2'($urandom_range(3)));
        end
        idle(LAT + 4);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
